// File: rtl/lzc_counter.sv
// Leading/trailing zero counter with empty flag; purely combinational
// priority encoder built as a log2-depth binary reduction tree.
module lzc_counter #(
  parameter int unsigned WIDTH = 2,
  parameter logic        MODE  = 1'b0,
  localparam int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  localparam int unsigned NUM_LEAVES = 32'(1) << CNT_WIDTH;
  localparam int unsigned NUM_NODES  = 2 * NUM_LEAVES - 1;

  if (WIDTH == 0) begin : gen_width_check
    $fatal(1, "lzc_counter: WIDTH must be at least 1");
  end

  logic [WIDTH-1:0]     in_scan;
  logic [NUM_NODES-1:0] node_vld;
  logic [CNT_WIDTH-1:0] node_idx [NUM_NODES];

  // Leading-zero mode scans a bit-reversed copy so the tree always favours index 0.
  for (genvar b = 0; b < WIDTH; b++) begin : gen_scan
    if (MODE) begin : gen_rev
      assign in_scan[b] = in_i[WIDTH-1-b];
    end else begin : gen_fwd
      assign in_scan[b] = in_i[b];
    end
  end

  // Heap layout: node n has children 2n+1 / 2n+2, leaf b sits at NUM_LEAVES-1+b.
  for (genvar b = 0; b < NUM_LEAVES; b++) begin : gen_leaf
    if (b < WIDTH) begin : gen_real
      assign node_vld[NUM_LEAVES-1+b] = in_scan[b];
    end else begin : gen_pad
      assign node_vld[NUM_LEAVES-1+b] = 1'b0;
    end
    assign node_idx[NUM_LEAVES-1+b] = '0;
  end

  for (genvar d = 0; d < CNT_WIDTH; d++) begin : gen_level
    for (genvar k = 0; k < (1 << d); k++) begin : gen_node
      localparam int unsigned N = (32'(1) << d) - 1 + k;
      localparam logic [CNT_WIDTH-1:0] SEL_BIT = CNT_WIDTH'(32'(1) << (CNT_WIDTH - 1 - d));
      logic sel;
      // Take the right (higher-index) child only when the left one is empty.
      assign sel         = ~node_vld[2*N+1] & node_vld[2*N+2];
      assign node_vld[N] = node_vld[2*N+1] | node_vld[2*N+2];
      assign node_idx[N] = sel ? (node_idx[2*N+2] | SEL_BIT) : node_idx[2*N+1];
    end
  end

  assign cnt_o   = node_idx[0];
  assign empty_o = ~node_vld[0];

  a_cnt_in_range: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !empty_o |-> (32'(cnt_o) < WIDTH)
  ) else $error("lzc_counter: cnt_o out of range");

  a_no_x_out: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !$isunknown(in_i) |-> !$isunknown({cnt_o, empty_o})
  ) else $error("lzc_counter: unknown on outputs with known input");

endmodule

// File: tb/tb_lzc_counter.sv
// Scoreboarded bench for lzc_counter across several WIDTH/MODE instances.
module tb_lzc_counter;

  typedef struct {
    int          id;
    string       tag;
    logic [31:0] cnt;
    logic        empty;
  } exp_t;

  logic clk;
  logic rst_n;

  logic [7:0] in_w8m0, in_w8m1;
  logic [4:0] in_w5m0, in_w5m1;
  logic [0:0] in_w1;
  logic [5:0] in_w6m0, in_w6m1;

  logic [2:0] cnt_w8m0, cnt_w8m1, cnt_w5m0, cnt_w5m1, cnt_w6m0, cnt_w6m1;
  logic [0:0] cnt_w1;
  logic       emp_w8m0, emp_w8m1, emp_w5m0, emp_w5m1, emp_w1, emp_w6m0, emp_w6m1;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_mis;

  lzc_counter #(.WIDTH(8), .MODE(1'b0)) u_w8m0 (.clk_i(clk), .rst_ni(rst_n), .in_i(in_w8m0), .cnt_o(cnt_w8m0), .empty_o(emp_w8m0));
  lzc_counter #(.WIDTH(8), .MODE(1'b1)) u_w8m1 (.clk_i(clk), .rst_ni(rst_n), .in_i(in_w8m1), .cnt_o(cnt_w8m1), .empty_o(emp_w8m1));
  lzc_counter #(.WIDTH(5), .MODE(1'b0)) u_w5m0 (.clk_i(clk), .rst_ni(rst_n), .in_i(in_w5m0), .cnt_o(cnt_w5m0), .empty_o(emp_w5m0));
  lzc_counter #(.WIDTH(5), .MODE(1'b1)) u_w5m1 (.clk_i(clk), .rst_ni(rst_n), .in_i(in_w5m1), .cnt_o(cnt_w5m1), .empty_o(emp_w5m1));
  lzc_counter #(.WIDTH(1), .MODE(1'b0)) u_w1   (.clk_i(clk), .rst_ni(rst_n), .in_i(in_w1),   .cnt_o(cnt_w1),   .empty_o(emp_w1));
  lzc_counter #(.WIDTH(6), .MODE(1'b0)) u_w6m0 (.clk_i(clk), .rst_ni(rst_n), .in_i(in_w6m0), .cnt_o(cnt_w6m0), .empty_o(emp_w6m0));
  lzc_counter #(.WIDTH(6), .MODE(1'b1)) u_w6m1 (.clk_i(clk), .rst_ni(rst_n), .in_i(in_w6m1), .cnt_o(cnt_w6m1), .empty_o(emp_w6m1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int id_width(int id);
    case (id)
      0, 1:    return 8;
      2, 3:    return 5;
      4:       return 1;
      default: return 6;
    endcase
  endfunction

  function automatic bit id_mode(int id);
    return (id == 1 || id == 3 || id == 6);
  endfunction

  // Reference: walk bits in scan order, count until the first one.
  function automatic logic [31:0] model_cnt(int w, bit m, logic [7:0] v);
    int p;
    for (int i = 0; i < w; i++) begin
      p = m ? (w - 1 - i) : i;
      if (v[p]) return 32'(i);
    end
    return 32'd0;
  endfunction

  function automatic logic model_empty(int w, logic [7:0] v);
    for (int i = 0; i < w; i++) begin
      if (v[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] get_cnt(int id);
    case (id)
      0:       return 32'(cnt_w8m0);
      1:       return 32'(cnt_w8m1);
      2:       return 32'(cnt_w5m0);
      3:       return 32'(cnt_w5m1);
      4:       return 32'(cnt_w1);
      5:       return 32'(cnt_w6m0);
      default: return 32'(cnt_w6m1);
    endcase
  endfunction

  function automatic logic get_empty(int id);
    case (id)
      0:       return emp_w8m0;
      1:       return emp_w8m1;
      2:       return emp_w5m0;
      3:       return emp_w5m1;
      4:       return emp_w1;
      5:       return emp_w6m0;
      default: return emp_w6m1;
    endcase
  endfunction

  task automatic drive(input int id, input logic [7:0] v, input string tag);
    exp_t e;
    case (id)
      0:       in_w8m0 = v;
      1:       in_w8m1 = v;
      2:       in_w5m0 = v[4:0];
      3:       in_w5m1 = v[4:0];
      4:       in_w1   = v[0:0];
      5:       in_w6m0 = v[5:0];
      default: in_w6m1 = v[5:0];
    endcase
    e.id    = id;
    e.tag   = tag;
    e.cnt   = model_cnt(id_width(id), id_mode(id), v);
    e.empty = model_empty(id_width(id), v);
    sb_q.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] obs_cnt;
    logic        obs_emp;
    @(negedge clk);
    while (sb_q.size() > 0) begin
      e       = sb_q.pop_front();
      obs_cnt = get_cnt(e.id);
      obs_emp = get_empty(e.id);
      n_cmp++;
      assert (obs_cnt === e.cnt) else begin
        n_mis++;
        $error("FAIL %s cnt observed=%0d expected=%0d", e.tag, obs_cnt, e.cnt);
      end
      n_cmp++;
      assert (obs_emp === e.empty) else begin
        n_mis++;
        $error("FAIL %s empty observed=%0b expected=%0b", e.tag, obs_emp, e.empty);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst_n = 1'b0;
    in_w8m0 = '0; in_w8m1 = '0; in_w5m0 = '0; in_w5m1 = '0;
    in_w1 = '0; in_w6m0 = '0; in_w6m1 = '0;

    // Outputs follow the input even while reset is held.
    drive(0, 8'b0010_1000, "rst_w8m0");
    drive(1, 8'b0010_1000, "rst_w8m1");
    drive(4, 8'h00,        "rst_w1_zero");
    check_all();
    rst_n = 1'b1;

    drive(0, 8'b0010_1000, "w8m0_28");
    drive(1, 8'b0010_1000, "w8m1_28");
    check_all();
    drive(0, 8'h01, "w8m0_01");
    drive(1, 8'h80, "w8m1_80");
    check_all();
    drive(0, 8'h80, "w8m0_80");
    drive(1, 8'h01, "w8m1_01");
    check_all();
    drive(0, 8'h00, "w8m0_empty");
    drive(1, 8'h00, "w8m1_empty");
    check_all();
    drive(0, 8'hff, "w8m0_ff");
    drive(1, 8'hff, "w8m1_ff");
    check_all();

    drive(2, 8'b1_0000, "w5m0_10");
    drive(3, 8'b0_0001, "w5m1_01");
    check_all();
    drive(2, 8'b0_0000, "w5m0_empty");
    drive(3, 8'b1_0000, "w5m1_10");
    check_all();
    drive(2, 8'b0_1100, "w5m0_0c");
    drive(3, 8'b0_0110, "w5m1_06");
    check_all();

    drive(4, 8'h01, "w1_one");
    check_all();
    drive(4, 8'h00, "w1_zero");
    check_all();

    for (int v = 0; v < 64; v++) begin
      drive(5, 8'(v), "sweep_w6m0");
      drive(6, 8'(v), "sweep_w6m1");
      check_all();
    end

    // Second sweep with reset pulsed partway through.
    for (int v = 0; v < 64; v++) begin
      if (v == 20) rst_n = 1'b0;
      if (v == 40) rst_n = 1'b1;
      drive(5, 8'(v), "rsweep_w6m0");
      drive(6, 8'(v), "rsweep_w6m1");
      check_all();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
